// File: rtl/irq_prio_pkg.sv
// Shared types and width helpers for the prioritised interrupt controller.
package irq_prio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // Index width for n items, never narrower than one bit.
  function automatic int clogMin1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/irq_prio_ctrl_prio_pick.sv
// Lowest-index-wins priority encoder over a W-bit vector.
module prio_pick
  import irq_prio_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = clogMin1(W)
) (
  input  logic [W-1:0]  vec,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Scan downwards so the lowest set bit is the last one written.
  always_comb begin
    any = |vec;
    idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/irq_prio_ctrl.sv
// Registered grouped interrupt controller: pending latch, two-level arbitration,
// valid/ready presentation and in-service tracking until end-of-interrupt.
module irq_prio_ctrl
  import irq_prio_pkg::*;
#(
  parameter int NCH  = 9,
  parameter int NGRP = 3,
  parameter int EDGE = 1,
  parameter int CW   = clogMin1(NCH),
  parameter int GW   = clogMin1(NGRP)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       en,
  input  logic [NGRP*NCH-1:0]  req,
  output logic [NGRP-1:0]      grp_act,
  output logic                 irq_valid,
  input  logic                 irq_ready,
  output logic [GW-1:0]        irq_grp,
  output logic [CW-1:0]        irq_chan,
  output logic                 busy,
  input  logic                 eoi
);

  localparam int N = NGRP * NCH;

  logic [N-1:0]    r_pend;
  logic [N-1:0]    r_reqQ;
  logic [N-1:0]    w_clr;
  irq_state_e      r_state;
  irq_state_e      w_stateNext;
  logic [NCH-1:0]  w_elig [NGRP];
  logic [NGRP-1:0] w_chanAny;
  logic [CW-1:0]   w_chanIdx [NGRP];
  logic            w_grpAny;
  logic [GW-1:0]   w_grpIdx;
  logic [CW-1:0]   w_winChan;
  logic            w_accept;

  for (genvar g = 0; g < NGRP; g++) begin : g_chanPick
    assign w_elig[g] = r_pend[g*NCH +: NCH] & en;
    prio_pick #(.W(NCH), .IW(CW)) u_chanPick (
      .vec (w_elig[g]),
      .any (w_chanAny[g]),
      .idx (w_chanIdx[g])
    );
  end

  prio_pick #(.W(NGRP), .IW(GW)) u_grpPick (
    .vec (w_chanAny),
    .any (w_grpAny),
    .idx (w_grpIdx)
  );

  always_comb begin
    w_winChan = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (w_grpIdx == GW'(g)) w_winChan = w_chanIdx[g];
    end
  end

  assign w_accept = (r_state == PRESENT) && irq_ready;

  always_comb begin
    w_clr = '0;
    for (int g = 0; g < NGRP; g++) begin
      for (int c = 0; c < NCH; c++) begin
        if (w_accept && irq_grp == GW'(g) && irq_chan == CW'(c)) w_clr[g*NCH+c] = 1'b1;
      end
    end
  end

  // A fresh edge outranks the acceptance clear so a re-request is never lost.
  always_ff @(posedge clk) begin
    r_reqQ <= req;
    if (!rst_n) begin
      r_pend  <= '0;
      grp_act <= '0;
    end else begin
      if (EDGE != 0) r_pend <= (r_pend & ~w_clr) | (req & ~r_reqQ);
      else           r_pend <= req;
      grp_act <= w_chanAny;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_grpAny) w_stateNext = PRESENT;
      PRESENT: if (irq_ready) w_stateNext = SERVICE;
      SERVICE: if (eoi) w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    irq_valid = (r_state == PRESENT);
    busy      = (r_state == SERVICE);
  end

  // The winner is captured only from IDLE, freezing it through PRESENT and SERVICE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_grp  <= '0;
      irq_chan <= '0;
    end else if (r_state == IDLE && w_grpAny) begin
      irq_grp  <= w_grpIdx;
      irq_chan <= w_winChan;
    end
  end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed scoreboard bench for irq_prio_ctrl: an edge-mode instance plus a level-mode one.
module tb_irq_prio_ctrl;
  import irq_prio_pkg::*;

  localparam int NCH = 9, NGRP = 3, CW = 4, GW = 2, N = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, irq_ready, eoi;
  logic [NCH-1:0] en;
  logic [N-1:0] req;
  logic [NGRP-1:0] grp_act;
  logic irq_valid, busy;
  logic [GW-1:0] irq_grp;
  logic [CW-1:0] irq_chan;

  logic rstL_n;
  logic [N-1:0] reqL;
  logic [NGRP-1:0] grpActL;
  logic validL, busyL;
  logic [GW-1:0] grpL;
  logic [CW-1:0] chanL;

  irq_prio_ctrl #(.NCH(NCH), .NGRP(NGRP), .EDGE(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .grp_act(grp_act),
    .irq_valid(irq_valid), .irq_ready(irq_ready), .irq_grp(irq_grp),
    .irq_chan(irq_chan), .busy(busy), .eoi(eoi)
  );

  irq_prio_ctrl #(.NCH(NCH), .NGRP(NGRP), .EDGE(0)) dutLevel (
    .clk(clk), .rst_n(rstL_n), .en(9'h1FF), .req(reqL), .grp_act(grpActL),
    .irq_valid(validL), .irq_ready(1'b0), .irq_grp(grpL),
    .irq_chan(chanL), .busy(busyL), .eoi(1'b0)
  );

  typedef struct packed {
    logic [GW-1:0] g;
    logic [CW-1:0] c;
  } exp_t;

  exp_t sbQ[$];
  int nCmp = 0;
  int nFail = 0;

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle request pulse on the given bits.
  task automatic applyStimulus(input logic [N-1:0] bits);
    req = bits;
    tick();
    req = '0;
  endtask

  task automatic expectIrq(input int g, input int c);
    exp_t e;
    e.g = GW'(g);
    e.c = CW'(c);
    sbQ.push_back(e);
  endtask

  task automatic waitPresent(input string tag);
    exp_t e;
    int n;
    n = 0;
    while (irq_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput({tag, "_valid"}, 32'(irq_valid), 32'd1);
    checkOutput({tag, "_sbNonEmpty"}, 32'(sbQ.size() != 0), 32'd1);
    if (sbQ.size() != 0) begin
      e = sbQ.pop_front();
      checkOutput({tag, "_grp"}, 32'(irq_grp), 32'(e.g));
      checkOutput({tag, "_chan"}, 32'(irq_chan), 32'(e.c));
    end
  endtask

  task automatic acceptAndEoi(input string tag);
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_validDrop"}, 32'(irq_valid), 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checkOutput({tag, "_eoiBusy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rstL_n = 1'b0; irq_ready = 1'b0; eoi = 1'b0;
    en = 9'h1FF; req = '0; reqL = '0;
    reqL[7] = 1'b1;
    tick(2);
    checkOutput("rst_valid", 32'(irq_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grpAct", 32'(grp_act), 32'd0);
    checkOutput("rst_grp", 32'(irq_grp), 32'd0);
    checkOutput("rst_chan", 32'(irq_chan), 32'd0);
    rst_n = 1'b1;
    tick(2);

    $display("[TB] single request");
    expectIrq(1, 4);
    req = 27'd1 << 13;
    tick();
    req = '0;
    checkOutput("single_latency", 32'(irq_valid), 32'd0);
    tick();
    checkOutput("single_grpAct", 32'(grp_act), 32'b010);
    waitPresent("single");
    acceptAndEoi("single");
    tick(4);
    checkOutput("single_pendCleared", 32'(irq_valid), 32'd0);

    $display("[TB] priority");
    expectIrq(1, 1); expectIrq(1, 3); expectIrq(2, 8);
    applyStimulus((27'd1 << 26) | (27'd1 << 10) | (27'd1 << 12));
    tick();
    checkOutput("prio_grpAct", 32'(grp_act), 32'b110);
    waitPresent("prio0"); acceptAndEoi("prio0");
    waitPresent("prio1"); acceptAndEoi("prio1");
    waitPresent("prio2"); acceptAndEoi("prio2");
    tick(3);

    $display("[TB] mask");
    en[3] = 1'b0;
    applyStimulus(27'd1 << 3);
    tick(4);
    checkOutput("mask_valid", 32'(irq_valid), 32'd0);
    checkOutput("mask_grpAct", 32'(grp_act), 32'd0);
    en = 9'h1FF;
    tick();
    checkOutput("mask_unmaskLatency", 32'(irq_valid), 32'd1);
    expectIrq(0, 3);
    waitPresent("mask");
    acceptAndEoi("mask");
    tick(3);

    $display("[TB] stall");
    expectIrq(2, 0);
    applyStimulus(27'd1 << 18);
    waitPresent("stall");
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_valid", 32'(irq_valid), 32'd1);
      checkOutput("stall_grp", 32'(irq_grp), 32'd2);
      checkOutput("stall_chan", 32'(irq_chan), 32'd0);
    end
    applyStimulus(27'd1 << 0);
    tick();
    checkOutput("stall_grpAct", 32'(grp_act), 32'b101);
    checkOutput("stall_frozenGrp", 32'(irq_grp), 32'd2);
    checkOutput("stall_frozenChan", 32'(irq_chan), 32'd0);
    acceptAndEoi("stall");
    expectIrq(0, 0);
    waitPresent("stallNext");
    acceptAndEoi("stallNext");
    tick(3);

    $display("[TB] edge collision");
    expectIrq(0, 5);
    applyStimulus(27'd1 << 5);
    waitPresent("coll");
    irq_ready = 1'b1;
    req = 27'd1 << 5;
    tick();
    irq_ready = 1'b0;
    req = '0;
    checkOutput("coll_busy", 32'(busy), 32'd1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    expectIrq(0, 5);
    waitPresent("collAgain");
    acceptAndEoi("collAgain");
    tick(4);
    checkOutput("coll_drained", 32'(irq_valid), 32'd0);

    $display("[TB] reset mid-service and level mode");
    expectIrq(0, 7);
    req = 27'd1 << 7;
    waitPresent("rstSvc");
    irq_ready = 1'b1;
    tick();
    irq_ready = 1'b0;
    checkOutput("rstSvc_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    checkOutput("rstSvc_valid", 32'(irq_valid), 32'd0);
    checkOutput("rstSvc_busyClr", 32'(busy), 32'd0);
    checkOutput("rstSvc_grp", 32'(irq_grp), 32'd0);
    checkOutput("rstSvc_chan", 32'(irq_chan), 32'd0);
    checkOutput("rstSvc_grpAct", 32'(grp_act), 32'd0);
    rst_n = 1'b1;
    rstL_n = 1'b1;
    tick();
    checkOutput("level_latency", 32'(validL), 32'd0);
    tick();
    checkOutput("level_valid", 32'(validL), 32'd1);
    checkOutput("level_grp", 32'(grpL), 32'd0);
    checkOutput("level_chan", 32'(chanL), 32'd7);
    tick(4);
    checkOutput("rstSvc_noEdge", 32'(irq_valid), 32'd0);
    checkOutput("rstSvc_noPend", 32'(grp_act), 32'd0);
    req = '0;
    checkOutput("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/irq_prio_ctrl.md
# irq_prio_ctrl

Parametrised, registered successor to the combinational 27-channel interrupt controller. It latches requests from `NGRP` priority groups of `NCH` channels each, gates them with a per-channel enable, and arbitrates the highest-priority pending request. The winner is presented on a valid/ready handshake and held in service until end-of-interrupt. It sits between the peripheral request lines and the CPU-side interrupt interface.

## Interface
- `NCH`, default 9: channels per group.
- `NGRP`, default 3: priority groups; group 0 is the highest priority.
- `EDGE`, default 1: 1 means rising-edge latched requests; 0 means level requests.
- `CW`, default `$clog2(NCH)` (min 1): channel index width.
- `GW`, default `$clog2(NGRP)` (min 1): group index width.
- `clk`  in  1  the single clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `en`  in  NCH  channel enable, shared by all groups.
- `req`  in  NGRP*NCH  requests; group g occupies `[g*NCH +: NCH]`.
- `grp_act`  out  NGRP  registered flag per group: some enabled request is pending in that group.
- `irq_valid`  out  1  an interrupt is presented.
- `irq_ready`  in  1  consumer accepts the presented interrupt.
- `irq_grp`  out  GW  group of the presented interrupt.
- `irq_chan`  out  CW  channel of the presented interrupt.
- `busy`  out  1  an interrupt is in service.
- `eoi`  in  1  single-cycle end-of-interrupt pulse.

## Operation
- Pending register `pend[NGRP*NCH]`:
  - EDGE=1: a bit sets on `req & ~req_q`. It clears when its interrupt is accepted.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - EDGE=0: `pend` is the registered copy of `req`. Acceptance does not clear it; the source must drop the request.
- Eligibility: `elig[g*NCH+c] = pend[g*NCH+c] & en[c]`. Dropping `en` never clears `pend`.
- Arbitration picks the lowest group index with any eligible bit, then the lowest channel index within that group.
- State machine, encoded in a shared enum:
  - IDLE: if any bit is eligible, register the winner into `irq_grp`/`irq_chan`, set `irq_valid`, and go to PRESENT.
  - PRESENT: `irq_valid`=1. The winner is frozen, even if its `en` or `pend` drops, or a higher-priority request arrives. When `irq_valid & irq_ready`: clear the pending bit (EDGE=1), drop `irq_valid`, set `busy`, and go to SERVICE.
  - SERVICE: `busy`=1 and no new interrupt is presented. When `eoi`=1: clear `busy` and go to IDLE.
- `eoi` in IDLE or PRESENT is ignored.
- `irq_ready` outside PRESENT is ignored.
- `grp_act[g]` = OR of `elig` over group g. It is updated every cycle, independent of state.
- Reset (`rst_n`=0 at a rising edge, any state, including mid-service):
  - `pend`, `req_q`, `grp_act`, `irq_grp`, `irq_chan`, `irq_valid` and `busy` all go to 0; state goes to IDLE.
  - Requests that were high during reset do not produce an edge afterwards. `req_q` is loaded with `req` during reset.

## Timing
- Request to presentation:
  - `req` rises at edge t; `pend` is set at t+1.
  - From IDLE, `irq_valid` is high after t+2, so latency is 2 cycles.
  - `grp_act` reflects the request after t+2.
- Handshake: accepted at edge t. At t+1 `irq_valid`=0, `busy`=1, and the pending bit is clear.
- `eoi` sampled at edge t: `busy`=0 at t+1. The next winner can be presented at t+2 (IDLE evaluates at t+1).
- Back-to-back service minimum: 1 cycle PRESENT + 1 cycle SERVICE + 1 cycle IDLE = 3 cycles per interrupt.
- `irq_grp`/`irq_chan` are only meaningful while `irq_valid` or `busy` is high. They hold their last value otherwise.

## Structure
- Package `irq_prio_pkg` holds:
  - the state enum `irq_state_e` {IDLE, PRESENT, SERVICE};
  - functions for the clog2-with-min-1 width computation.
- Sub-module `prio_pick`: a parametrised lowest-index priority encoder, (`vec[W]`) → (`any`, `idx[$clog2 W]`).
  - Instantiated NGRP times for channel selection, once for group selection.
  - Combinational only.
- Top level holds the pending logic, the FSM and the output registers.

## Test plan
- Single request, NCH=9, NGRP=3, EDGE=1, `en`=9'h1FF:
  - Stimulus: pulse `req[13]` (group 1, channel 4).
  - Required: `irq_valid`=1 two cycles later with `irq_grp`=1, `irq_chan`=4, `grp_act`=3'b010.
  - `irq_ready`=1 → `busy`=1 and `pend[13]`=0; `eoi` → `busy`=0.
- Priority:
  - Stimulus: raise `req[26]`, `req[10]` and `req[12]` in the same cycle.
  - Required: presented in order (1,1), (1,3), (2,8), with an `eoi` between each.
- Mask:
  - Stimulus: `en[3]`=0, pulse `req[3]`.
  - Required: no `irq_valid` and `grp_act`=0. After `en[3]`=1, (0,3) is presented 1 cycle later.
- Stability under stall:
  - Stimulus: present (2,0) with `irq_ready`=0 for 5 cycles, then raise `req[0]`.
  - Required: outputs stay at (2,0) until accepted. After `eoi`, (0,0) is presented.
- Edge collision:
  - Stimulus: a re-edge on `req[5]` in the same cycle as acceptance of (0,5).
  - Required: `pend[5]` stays 1 and (0,5) is presented again after `eoi`.
- Reset mid-service and level mode:
  - Stimulus: `rst_n`=0 for one cycle while `busy`=1 and `req[7]` is held high.
  - Required: every output is 0; no presentation afterwards with EDGE=1. With EDGE=0, (0,7) is presented 2 cycles after reset release.
